cpu_debug_writer: RTL and testbench
===================================

// Module: cpu_debug_writer
// PURPOSE
//  Write-side companion to the CPU debug display path: lets the operator deposit a value into CPU RAM or the
//  register file from board switches and buttons. Address is latched from switches, data is shifted in one hex
//  digit per press, and a commit issues one write to the CPU debug write port over a req/ack handshake.
//  Sits beside the CPU on the main clock, after the button debouncers; staged address/data feed the 7-seg display.
// PARAMETERS
//  p_data_width          16       CPU word width; multiple of 4 (hex digits = p_data_width/4)
//  p_address_width       10       RAM address width = switch bank width
//  p_regs_address_width  3        register-file address width (low bits of latched address)
//  p_timeout_cycles      1000     clocks to wait for ack before aborting
// PORTS
//  i_w_clk          in   1                     main clock
//  i_w_reset        in   1                     synchronous, active-high reset
//  i_w_in           in   p_address_width       switch bank
//  i_w_sel_regs     in   1                     target: 0 = RAM, 1 = register file (sampled at commit)
//  i_w_load_addr    in   1                     debounced button level: latch address
//  i_w_load_data    in   1                     debounced button level: shift in one hex digit
//  i_w_commit       in   1                     debounced button level: issue write
//  i_w_wr_ack       in   1                     CPU write acknowledge, single-cycle pulse
//  o_w_wr_req       out  1                     write request level
//  o_w_wr_regs      out  1                     write target (1 = regs)
//  o_w_wr_addr      out  p_address_width       write address (regs use low p_regs_address_width bits, upper bits 0)
//  o_w_wr_data      out  p_data_width          write data
//  o_w_stage_addr   out  p_address_width       staged address, for display
//  o_w_stage_data   out  p_data_width          staged data, for display
//  o_w_busy         out  1                     transaction in flight
//  o_w_error        out  1                     sticky: last commit timed out
//  o_w_wr_count     out  8                     completed-write counter
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, staging regs 0, timeout counter 0, edge-detect history 0 (a held button
//    does not fire after reset release until released and pressed again).
//  - Buttons: rising-edge detected internally (one registered history bit each); action on the edge cycle.
//  - Same-cycle edges, priority: commit > load_addr > load_data; lower-priority edges in that cycle dropped.
//  - All button edges ignored while not IDLE (no queuing).
//  - load_addr (IDLE): stage_addr <= i_w_in, next cycle.
//  - load_data (IDLE): stage_data <= {stage_data[p_data_width-5:0], i_w_in[3:0]}; oldest digit shifts out.
//  - FSM: IDLE --commit edge--> REQ --ack--> DONE --1 cycle--> IDLE; REQ --timeout--> IDLE.
//  - Commit edge: cycle N+1 req=1, busy=1, error cleared; wr_addr/wr_data/wr_regs captured from stage
//    regs and i_w_sel_regs at N and held stable for the whole request; if regs, wr_addr upper bits forced 0.
//  - REQ: ack sampled high at cycle M -> req=0 at M+1 (DONE), wr_count +1 (mod 256), busy=0 at M+2.
//  - Ack while not REQ ignored. Ack in the same cycle the timeout expires: ack wins (success).
//  - Timeout: counter counts REQ cycles; at p_timeout_cycles without ack -> req=0, error=1, IDLE, no count.
//  - Staging regs unchanged by a write; repeated commits re-write same values.
//  - Reset mid-transaction: req drops on the reset edge; no completion counted.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/REQ/DONE), target encoding constants (RAM=0, REGS=1).
//  - One sub-module: dbg_edge_detect (level in -> single-cycle rising pulse, sync reset), instanced x3.
//  - Timeout counter width = $clog2(p_timeout_cycles+1).
// TESTING
//  1. Reset held, all buttons high -> all outputs 0; release reset, buttons stay high -> no action.
//  2. i_w_in=0x2A load_addr; digits 1,2,3,4 via load_data; commit, sel_regs=0, ack 3 cycles after req ->
//     req held 3 cycles with addr=0x02A data=0x1234, drops next cycle, wr_count=1, busy low 2 cycles post-ack.
//  3. stage_addr=0x3FF, sel_regs=1, commit -> wr_addr=0x007, wr_regs=1.
//  4. Commit, no ack -> req high exactly p_timeout_cycles cycles, error=1, wr_count unchanged; next commit clears error.
//  5. Commit and load_data edges same cycle -> write issued, stage_data unchanged; load_data during REQ ignored.
//  6. Reset asserted 2 cycles into REQ -> req=0 next edge, wr_count=0; late ack after reset ignored.

Source files
------------

// File: rtl/cpu_debug_writer_pkg.sv
// Shared encodings for the CPU debug write path.
package cpu_debug_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

  localparam logic TGT_RAM  = 1'b0;
  localparam logic TGT_REGS = 1'b1;

endpackage

// File: rtl/cpu_debug_writer_edge_detect.sv
// Button level to single-cycle rising-edge pulse. A button already held when
// reset releases must be seen low once before it can fire.
module dbg_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_pulse
);

  logic hist_q, hist_d;
  logic armed_q, armed_d;

  // next history and arming state
  always_comb begin
    hist_d  = i_level;
    armed_d = armed_q | ~i_level;
  end

  assign o_pulse = i_level & ~hist_q & armed_q;

  // history registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/cpu_debug_writer.sv
// Operator-driven debug writer: stage address/data from switches, commit one
// write to the CPU debug port over a req/ack handshake with timeout.
module cpu_debug_writer
  import cpu_debug_writer_pkg::*;
#(
  parameter int p_data_width         = 16,
  parameter int p_address_width      = 10,
  parameter int p_regs_address_width = 3,
  parameter int p_timeout_cycles     = 1000
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic [p_address_width-1:0] i_w_in,
  input  logic                       i_w_sel_regs,
  input  logic                       i_w_load_addr,
  input  logic                       i_w_load_data,
  input  logic                       i_w_commit,
  input  logic                       i_w_wr_ack,
  output logic                       o_w_wr_req,
  output logic                       o_w_wr_regs,
  output logic [p_address_width-1:0] o_w_wr_addr,
  output logic [p_data_width-1:0]    o_w_wr_data,
  output logic [p_address_width-1:0] o_w_stage_addr,
  output logic [p_data_width-1:0]    o_w_stage_data,
  output logic                       o_w_busy,
  output logic                       o_w_error,
  output logic [7:0]                 o_w_wr_count
);

  localparam int unsigned CNT_W = $clog2(p_timeout_cycles + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(p_timeout_cycles - 1);

  logic commit_p, load_addr_p, load_data_p;

  dbg_edge_detect u_edge_commit (
    .i_clk(i_w_clk), .i_reset(i_w_reset), .i_level(i_w_commit), .o_pulse(commit_p)
  );
  dbg_edge_detect u_edge_load_addr (
    .i_clk(i_w_clk), .i_reset(i_w_reset), .i_level(i_w_load_addr), .o_pulse(load_addr_p)
  );
  dbg_edge_detect u_edge_load_data (
    .i_clk(i_w_clk), .i_reset(i_w_reset), .i_level(i_w_load_data), .o_pulse(load_data_p)
  );

  wr_state_e                  state_q, state_d;
  logic                       req_q, req_d;
  logic                       wr_regs_q, wr_regs_d;
  logic [p_address_width-1:0] wr_addr_q, wr_addr_d;
  logic [p_data_width-1:0]    wr_data_q, wr_data_d;
  logic [p_address_width-1:0] stage_addr_q, stage_addr_d;
  logic [p_data_width-1:0]    stage_data_q, stage_data_d;
  logic                       busy_q, busy_d;
  logic                       error_q, error_d;
  logic [7:0]                 count_q, count_d;
  logic [CNT_W-1:0]           tmo_q, tmo_d;

  // staging, handshake FSM and timeout next-state logic
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    wr_regs_d    = wr_regs_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    busy_d       = busy_q;
    error_d      = error_q;
    count_d      = count_q;
    tmo_d        = tmo_q;

    case (state_q)
      ST_IDLE: begin
        // commit outranks loads; lower-priority edges in the same cycle are dropped
        if (commit_p) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          tmo_d     = '0;
          wr_regs_d = i_w_sel_regs;
          wr_data_d = stage_data_q;
          if (i_w_sel_regs == TGT_REGS) begin
            wr_addr_d = p_address_width'(stage_addr_q[p_regs_address_width-1:0]);
          end else begin
            wr_addr_d = stage_addr_q;
          end
        end else if (load_addr_p) begin
          stage_addr_d = i_w_in;
        end else if (load_data_p) begin
          stage_data_d = {stage_data_q[p_data_width-5:0], i_w_in[3:0]};
        end
      end
      ST_REQ: begin
        // ack is checked before expiry so a last-cycle ack still succeeds
        if (i_w_wr_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          count_d = count_q + 8'd1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      wr_regs_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      count_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      wr_regs_q    <= wr_regs_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign o_w_wr_req     = req_q;
  assign o_w_wr_regs    = wr_regs_q;
  assign o_w_wr_addr    = wr_addr_q;
  assign o_w_wr_data    = wr_data_q;
  assign o_w_stage_addr = stage_addr_q;
  assign o_w_stage_data = stage_data_q;
  assign o_w_busy       = busy_q;
  assign o_w_error      = error_q;
  assign o_w_wr_count   = count_q;

endmodule

// File: tb/tb_cpu_debug_writer.sv
// Bench for cpu_debug_writer: staging vector table, write scoreboard, and
// hand sequences for handshake, timeout and reset corner cases.
module tb_cpu_debug_writer;

  localparam int TB_T = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  din;
  logic        sel_regs, b_la, b_ld, b_commit, ack;
  logic        o_req, o_regs, o_busy, o_error;
  logic [9:0]  o_addr, o_saddr;
  logic [15:0] o_data, o_sdata;
  logic [7:0]  o_count;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        la;
    logic        ld;
    logic [9:0]  din;
    logic [9:0]  e_addr;
    logic [15:0] e_data;
  } vec_t;

  typedef struct packed {
    logic        regs;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  vec_t vecs[7];
  wr_t  exp_q[$];
  wr_t  cur_wr;
  logic mon_prev = 1'b0;

  cpu_debug_writer #(
    .p_data_width(16),
    .p_address_width(10),
    .p_regs_address_width(3),
    .p_timeout_cycles(TB_T)
  ) dut (
    .i_w_clk(clk),
    .i_w_reset(rst),
    .i_w_in(din),
    .i_w_sel_regs(sel_regs),
    .i_w_load_addr(b_la),
    .i_w_load_data(b_ld),
    .i_w_commit(b_commit),
    .i_w_wr_ack(ack),
    .o_w_wr_req(o_req),
    .o_w_wr_regs(o_regs),
    .o_w_wr_addr(o_addr),
    .o_w_wr_data(o_data),
    .o_w_stage_addr(o_saddr),
    .o_w_stage_data(o_sdata),
    .o_w_busy(o_busy),
    .o_w_error(o_error),
    .o_w_wr_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit();
    b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
  endtask

  // scoreboard: pop expected write on req rise, hold it while req stays high
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
    end else begin
      if (o_req && !mon_prev) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got write 0x%0h expected none", {o_regs, o_addr, o_data});
        end else begin
          cur_wr = exp_q.pop_front();
          check("sb_write", 32'({o_regs, o_addr, o_data}), 32'(cur_wr));
        end
      end else if (o_req) begin
        check("sb_stable", 32'({o_regs, o_addr, o_data}), 32'(cur_wr));
      end
      mon_prev = o_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b1, 10'h155, 10'h155, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 10'h3FB, 10'h155, 16'h000B};
    vecs[2] = '{1'b1, 1'b0, 10'h02A, 10'h02A, 16'h000B};
    vecs[3] = '{1'b0, 1'b1, 10'h001, 10'h02A, 16'h00B1};
    vecs[4] = '{1'b0, 1'b1, 10'h002, 10'h02A, 16'h0B12};
    vecs[5] = '{1'b0, 1'b1, 10'h003, 10'h02A, 16'hB123};
    vecs[6] = '{1'b0, 1'b1, 10'h004, 10'h02A, 16'h1234};

    // reset with all buttons held
    rst = 1'b1; din = 10'h155; sel_regs = 1'b0; ack = 1'b0;
    b_la = 1'b1; b_ld = 1'b1; b_commit = 1'b1;
    repeat (3) tick();
    check("rst_outs", 32'({o_req, o_regs, o_busy, o_error, o_count}), 32'd0);
    check("rst_wr", 32'({o_addr, o_data}), 32'd0);
    check("rst_stage", 32'({o_saddr, o_sdata}), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("held_no_action", 32'({o_req, o_busy, o_saddr, o_sdata}), 32'd0);
    b_la = 1'b0; b_ld = 1'b0; b_commit = 1'b0;
    repeat (2) tick();

    // staging vectors
    for (int i = 0; i < 7; i++) begin
      din = vecs[i].din; b_la = vecs[i].la; b_ld = vecs[i].ld;
      tick();
      b_la = 1'b0; b_ld = 1'b0;
      tick();
      check($sformatf("vec%0d_addr", i), 32'(o_saddr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_data", i), 32'(o_sdata), 32'(vecs[i].e_data));
    end

    // RAM write, ack after three request cycles
    exp_q.push_back('{1'b0, 10'h02A, 16'h1234});
    do_commit();
    check("c1_req_busy", 32'({o_req, o_busy, o_error}), 32'b110);
    tick(); check("c1_req2", 32'(o_req), 32'd1);
    tick(); check("c1_req3", 32'(o_req), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("c1_done", 32'({o_req, o_busy, o_count}), 32'({1'b0, 1'b1, 8'd1}));
    tick(); check("c1_idle_busy", 32'(o_busy), 32'd0);

    // register-file write truncates address
    din = 10'h3FF; b_la = 1'b1; tick(); b_la = 1'b0; tick();
    sel_regs = 1'b1;
    exp_q.push_back('{1'b1, 10'h007, 16'h1234});
    do_commit();
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("c2_count", 32'(o_count), 32'd2);
    check("c2_stage_kept", 32'(o_saddr), 32'h3FF);

    // timeout with no ack
    sel_regs = 1'b0;
    exp_q.push_back('{1'b0, 10'h3FF, 16'h1234});
    do_commit();
    n = 0;
    while (o_req && n < TB_T + 5) begin n++; tick(); end
    check("to_req_cycles", 32'(n), 32'(TB_T));
    check("to_flags", 32'({o_req, o_busy, o_error, o_count}), 32'({1'b0, 1'b0, 1'b1, 8'd2}));

    // next commit clears error
    exp_q.push_back('{1'b0, 10'h3FF, 16'h1234});
    do_commit();
    check("rc_err_clr", 32'({o_req, o_error}), 32'b10);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("rc_count", 32'(o_count), 32'd3);

    // ack in the final timeout cycle wins
    exp_q.push_back('{1'b0, 10'h3FF, 16'h1234});
    do_commit();
    repeat (TB_T - 1) tick();
    check("edge_req_last", 32'(o_req), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("edge_ack_wins", 32'({o_req, o_busy, o_error, o_count}), 32'({1'b0, 1'b1, 1'b0, 8'd4}));
    tick();

    // commit + load_data same cycle, loads during REQ ignored
    exp_q.push_back('{1'b0, 10'h3FF, 16'h1234});
    din = 10'h00F; b_commit = 1'b1; b_ld = 1'b1;
    tick();
    b_commit = 1'b0; b_ld = 1'b0;
    check("pri_req", 32'(o_req), 32'd1);
    check("pri_data_kept", 32'(o_sdata), 32'h1234);
    tick();
    din = 10'h0AA; b_ld = 1'b1; b_la = 1'b1; tick();
    b_ld = 1'b0; b_la = 1'b0; tick();
    check("busy_ld_ignored", 32'({o_saddr, o_sdata}), 32'({10'h3FF, 16'h1234}));
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("pri_count", 32'(o_count), 32'd5);

    // ack while idle ignored
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("idle_ack", 32'({o_req, o_busy, o_count}), 32'({1'b0, 1'b0, 8'd5}));

    // reset two cycles into REQ, late ack ignored
    exp_q.push_back('{1'b0, 10'h3FF, 16'h1234});
    do_commit();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst", 32'({o_req, o_busy, o_count}), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("late_ack", 32'({o_req, o_busy, o_count}), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
